ifetch_ctrl: RTL and testbench

//  Sequences instruction memory: owns the PC, drives imem addr, captures imem rdata.

---
 rtl/ifetch_ctrl_pkg.sv | 22 ++
 rtl/ifetch_fifo.sv | 55 +++++
 rtl/ifetch_ctrl.sv | 114 +++++++++++
 tb/tb_ifetch_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_ctrl_pkg.sv
// Shared constants, FSM encodings and the FIFO entry layout for the instruction fetch controller.
// Optional feature macro used by this block: IFETCH_MISALIGN_TRAP_EN.
package ifetch_ctrl_pkg;

    localparam int XLEN       = 32;
    localparam int ILEN_BYTES = 4;

    localparam logic [1:0] ST_BOOT   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

    // Clear the sub-word offset so the pc always points at an instruction boundary.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(ILEN_BYTES - 1);
    endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Small synchronous FIFO buffering fetched {pc, inst} pairs; flush wins over push and pop.
// Storage is plain registers; only pointers and count are reset.
module ifetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && !flush && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // NOTE: sequential state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array is deliberately not reset; an entry is never read until count says it was written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller: owns the pc, drives imem, buffers {pc, inst} for decode,
// handles redirect/flush and halt/resume. Define IFETCH_MISALIGN_TRAP_EN to trap misaligned redirects.
module ifetch_ctrl
    import ifetch_ctrl_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            halt_req,
    input  logic            resume,
    output logic            halted
`ifdef IFETCH_MISALIGN_TRAP_EN
    ,
    output logic            fetch_misalign,
    output logic [XLEN-1:0] fetch_misalign_pc
`endif
);

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_next;
    logic [1:0]      state;
    logic [1:0]      state_next;
    logic            push;
    logic            pop;
    logic            full;
    logic            empty;
    logic            misalign;
    fetch_entry_t    head;
    fetch_entry_t    last_head;

`ifdef IFETCH_MISALIGN_TRAP_EN
    assign misalign = redirect && (redirect_pc[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    assign imem_addr  = pc;
    assign inst_valid = !empty;
    assign pop        = inst_valid && inst_ready;
    assign push       = (state == ST_RUN) && !redirect && (!full || pop);
    assign halted     = (state == ST_HALTED) && empty;

    // With nothing buffered the outputs hold the last head seen (zero out of reset).
    assign inst    = inst_valid ? head.inst : last_head.inst;
    assign inst_pc = inst_valid ? head.pc   : last_head.pc;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        case (state)
            ST_BOOT:   state_next = ST_RUN;
            ST_RUN:    if (halt_req) state_next = ST_HALTED;
            ST_HALTED: if (resume)   state_next = ST_RUN;
            default:   state_next = ST_BOOT;
        endcase
        if (redirect) begin
            if (halt_req || misalign) state_next = ST_HALTED;
            if (!misalign)            pc_next    = align_pc(redirect_pc);
        end else if (push) begin
            pc_next = pc + XLEN'(ILEN_BYTES);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc        <= RESET_PC;
            state     <= ST_BOOT;
            last_head <= '0;
        end else begin
            pc    <= pc_next;
            state <= state_next;
            if (inst_valid) last_head <= head;
        end
    end

`ifdef IFETCH_MISALIGN_TRAP_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_misalign    <= 1'b0;
            fetch_misalign_pc <= '0;
        end else begin
            fetch_misalign <= misalign;
            if (misalign) fetch_misalign_pc <= redirect_pc;
        end
    end
`endif

    ifetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .wdata ({pc, imem_rdata}),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed testbench for ifetch_ctrl: streaming, backpressure, halt/resume, redirect, pc wrap.
// Exercises the misaligned-redirect trap when IFETCH_MISALIGN_TRAP_EN is defined.
module tb_ifetch_ctrl;

    logic        clk;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt_req;
    logic        resume;
    logic        halted;
`ifdef IFETCH_MISALIGN_TRAP_EN
    logic        fetch_misalign;
    logic [31:0] fetch_misalign_pc;
`endif

    int tests_run;
    int tests_failed;

    ifetch_ctrl #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt_req    (halt_req),
        .resume      (resume),
        .halted      (halted)
`ifdef IFETCH_MISALIGN_TRAP_EN
        ,
        .fetch_misalign    (fetch_misalign),
        .fetch_misalign_pc (fetch_misalign_pc)
`endif
    );

    // Instruction memory model: each address returns a recognisable word.
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return 32'hA000_0000 ^ (addr >> 2);
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_head(input string tag, input logic [31:0] exp_pc);
        check({tag, " valid"}, 32'(inst_valid), 32'd1);
        check({tag, " pc"}, inst_pc, exp_pc);
        check({tag, " inst"}, inst, mem_word(exp_pc));
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        inst_ready   = 1'b0;
        redirect     = 1'b0;
        redirect_pc  = '0;
        halt_req     = 1'b0;
        resume       = 1'b0;

        // Reset state
        step();
        step();
        check("rst valid", 32'(inst_valid), 32'd0);
        check("rst halted", 32'(halted), 32'd0);
        check("rst inst", inst, 32'd0);
        check("rst inst_pc", inst_pc, 32'd0);
        check("rst addr", imem_addr, 32'd0);

        // Streaming with inst_ready held high: one inst per cycle from cycle 2
        reset      = 1'b0;
        inst_ready = 1'b1;
        check("boot valid", 32'(inst_valid), 32'd0);
        step();
        check("c1 valid", 32'(inst_valid), 32'd0);
        check("c1 addr", imem_addr, 32'd0);
        step();
        for (int k = 0; k < 8; k++) begin
            check_head($sformatf("stream%0d", k), 32'(4 * k));
            step();
        end

        // Backpressure from a fresh reset: fills at DEPTH, pc stalls at 8
        reset      = 1'b1;
        inst_ready = 1'b0;
        step();
        reset = 1'b0;
        repeat (5) step();
        check("stall addr", imem_addr, 32'h8);
        check_head("stall head", 32'h0);
        inst_ready = 1'b1;
        step();
        check_head("release0", 32'h4);
        step();
        inst_ready = 1'b0;
        check_head("release1", 32'h8);
        check("refill addr", imem_addr, 32'h10);

        // Halt with 0x8, 0xC buffered: both drain, then halted
        halt_req = 1'b1;
        step();
        halt_req   = 1'b0;
        inst_ready = 1'b1;
        check("halt drain halted", 32'(halted), 32'd0);
        check_head("drain0", 32'h8);
        check("halt addr", imem_addr, 32'h10);
        step();
        check_head("drain1", 32'hC);
        step();
        check("halted valid", 32'(inst_valid), 32'd0);
        check("halted", 32'(halted), 32'd1);
        step();
        check("halted hold", 32'(halted), 32'd1);
        check("halted addr", imem_addr, 32'h10);
        resume = 1'b1;
        step();
        resume = 1'b0;
        check("resumed halted", 32'(halted), 32'd0);
        step();
        inst_ready = 1'b0;
        check_head("resume head", 32'h10);

        // Redirect with two entries buffered: flush, nothing old survives
        step();
        check_head("pre-redirect", 32'h10);
        check("pre-redirect addr", imem_addr, 32'h18);
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        step();
        redirect   = 1'b0;
        inst_ready = 1'b1;
        check("flush valid", 32'(inst_valid), 32'd0);
        check("redirect addr", imem_addr, 32'h100);
        step();
        check_head("redir0", 32'h100);
        step();
        check_head("redir1", 32'h104);

        // Low redirect_pc bits are dropped when the trap is not built in
`ifndef IFETCH_MISALIGN_TRAP_EN
        redirect    = 1'b1;
        redirect_pc = 32'h203;
        step();
        redirect = 1'b0;
        check("align addr", imem_addr, 32'h200);
        step();
        check_head("align head", 32'h200);
`endif

        // pc wrap from 0xFFFF_FFFC
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect = 1'b0;
        check("wrap addr", imem_addr, 32'hFFFF_FFFC);
        step();
        check_head("wrap top", 32'hFFFF_FFFC);
        check("wrap addr0", imem_addr, 32'h0);
        step();
        check_head("wrap zero", 32'h0);
        check("wrap addr4", imem_addr, 32'h4);

`ifdef IFETCH_MISALIGN_TRAP_EN
        // Misaligned redirect: pc held, flush, trap pulse, halt
        redirect    = 1'b1;
        redirect_pc = 32'h102;
        step();
        redirect = 1'b0;
        check("mis pulse", 32'(fetch_misalign), 32'd1);
        check("mis pc", fetch_misalign_pc, 32'h102);
        check("mis addr", imem_addr, 32'h4);
        check("mis halted", 32'(halted), 32'd1);
        step();
        check("mis pulse end", 32'(fetch_misalign), 32'd0);
        check("mis still halted", 32'(halted), 32'd1);
        resume = 1'b1;
        step();
        resume = 1'b0;
        step();
        check_head("mis resume", 32'h4);
`endif

        // Redirect and halt together, then redirect while halted
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        halt_req    = 1'b1;
        step();
        redirect = 1'b0;
        halt_req = 1'b0;
        check("rh halted", 32'(halted), 32'd1);
        check("rh addr", imem_addr, 32'h40);
        step();
        check("rh valid", 32'(inst_valid), 32'd0);
        check("rh addr hold", imem_addr, 32'h40);
        redirect    = 1'b1;
        redirect_pc = 32'h80;
        step();
        redirect = 1'b0;
        check("hr halted", 32'(halted), 32'd1);
        check("hr addr", imem_addr, 32'h80);
        resume = 1'b1;
        step();
        resume = 1'b0;
        step();
        check_head("hr resume", 32'h80);

        // Reset mid-operation with buffered entries
        inst_ready = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        check("mid rst valid", 32'(inst_valid), 32'd0);
        check("mid rst inst_pc", inst_pc, 32'd0);
        check("mid rst inst", inst, 32'd0);
        check("mid rst addr", imem_addr, 32'd0);
        check("mid rst halted", 32'(halted), 32'd0);
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
